// File: rtl/arm_decode_stage.sv
// ID stage of the ARM subset pipeline: register file, control unit and
// condition check. Everything except the register file is combinational.
module arm_decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [31:0] result_wb,
  input  logic        write_back_en,
  input  logic [3:0]  dest_wb,
  input  logic        hazard,
  input  logic [3:0]  sr,
  output logic        wb_en,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic        b,
  output logic        s,
  output logic [3:0]  exe_cmd,
  output logic [31:0] val_rn,
  output logic [31:0] val_rm,
  output logic        imm,
  output logic [11:0] shift_operand,
  output logic [23:0] signed_imm_24,
  output logic [3:0]  dest,
  output logic [3:0]  src1,
  output logic [3:0]  src2,
  output logic        two_src
);

  typedef struct packed {
    logic       wb;
    logic       mr;
    logic       mw;
    logic       b;
    logic       s;
    logic [3:0] cmd;
  } ctrl_t;

  logic [31:0] rf [15];
  logic [1:0]  mode;
  logic [3:0]  opcode;
  logic        s_bit;
  logic [3:0]  cond;
  logic        n_f, z_f, c_f, v_f;
  logic        cond_ok;
  ctrl_t       ctrl, ctrl_q;

  assign mode          = inst[27:26];
  assign opcode        = inst[24:21];
  assign s_bit         = inst[20];
  assign cond          = inst[31:28];
  assign {n_f, z_f, c_f, v_f} = sr;

  assign imm           = inst[25];
  assign shift_operand = inst[11:0];
  assign signed_imm_24 = inst[23:0];
  assign dest          = inst[15:12];
  assign src1          = inst[19:16];
  // Stores read Rd as the data operand, so the second port follows Rd
  assign src2          = ctrl.mw ? inst[15:12] : inst[3:0];
  assign two_src       = ~inst[25] | ctrl.mw;

  // Written on the falling edge so WB data is readable in the same cycle
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 15; i++) rf[i] <= 32'(i);
    end else if (write_back_en) begin
      for (int i = 0; i < 15; i++)
        if (dest_wb == 4'(i)) rf[i] <= result_wb;
    end
  end

  always_comb begin
    val_rn = '0;
    val_rm = '0;
    for (int i = 0; i < 15; i++) begin
      if (src1 == 4'(i)) val_rn = rf[i];
      if (src2 == 4'(i)) val_rm = rf[i];
    end
  end

  always_comb begin
    ctrl = '0;
    unique case (mode)
      2'b00: begin
        ctrl.s  = s_bit;
        ctrl.wb = 1'b1;
        case (opcode)
          4'b1101: ctrl.cmd = 4'b0001;
          4'b1111: ctrl.cmd = 4'b1001;
          4'b0100: ctrl.cmd = 4'b0010;
          4'b0101: ctrl.cmd = 4'b0011;
          4'b0010: ctrl.cmd = 4'b0100;
          4'b0110: ctrl.cmd = 4'b0101;
          4'b0000: ctrl.cmd = 4'b0110;
          4'b1100: ctrl.cmd = 4'b0111;
          4'b0001: ctrl.cmd = 4'b1000;
          4'b1010: begin ctrl.cmd = 4'b0100; ctrl.wb = 1'b0; end
          4'b1000: begin ctrl.cmd = 4'b0110; ctrl.wb = 1'b0; end
          default: ctrl = '0;
        endcase
      end
      2'b01: begin
        ctrl.cmd = 4'b0010;
        ctrl.mr  = s_bit;
        ctrl.wb  = s_bit;
        ctrl.mw  = ~s_bit;
      end
      2'b10:   ctrl.b = 1'b1;
      default: ctrl = '0;
    endcase
  end

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'b0000: cond_ok = z_f;
      4'b0001: cond_ok = ~z_f;
      4'b0010: cond_ok = c_f;
      4'b0011: cond_ok = ~c_f;
      4'b0100: cond_ok = n_f;
      4'b0101: cond_ok = ~n_f;
      4'b0110: cond_ok = v_f;
      4'b0111: cond_ok = ~v_f;
      4'b1000: cond_ok = c_f & ~z_f;
      4'b1001: cond_ok = ~c_f | z_f;
      4'b1010: cond_ok = (n_f == v_f);
      4'b1011: cond_ok = (n_f != v_f);
      4'b1100: cond_ok = ~z_f & (n_f == v_f);
      4'b1101: cond_ok = z_f | (n_f != v_f);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  assign ctrl_q   = (cond_ok && !hazard) ? ctrl : '0;
  assign wb_en    = ctrl_q.wb;
  assign mem_r_en = ctrl_q.mr;
  assign mem_w_en = ctrl_q.mw;
  assign b        = ctrl_q.b;
  assign s        = ctrl_q.s;
  assign exe_cmd  = ctrl_q.cmd;

endmodule

// File: tb/tb_arm_decode_stage.sv
// Directed scoreboard bench for arm_decode_stage: stimulus pushes expected
// decode results, a posedge monitor pops and compares.
module tb_arm_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst, result_wb;
  logic        write_back_en, hazard;
  logic [3:0]  dest_wb, sr;
  logic        wb_en, mem_r_en, mem_w_en, b, s, imm, two_src;
  logic [3:0]  exe_cmd, dest, src1, src2;
  logic [31:0] val_rn, val_rm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [8:0]  ctl;   // {wb, mr, mw, b, s, cmd[3:0]}
    logic [31:0] rn, rm;
    logic [3:0]  src1, src2, dest;
    logic        two;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;

  arm_decode_stage dut (
    .clk(clk), .rst(rst), .inst(inst), .result_wb(result_wb),
    .write_back_en(write_back_en), .dest_wb(dest_wb), .hazard(hazard), .sr(sr),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .b(b), .s(s),
    .exe_cmd(exe_cmd), .val_rn(val_rn), .val_rm(val_rm), .imm(imm),
    .shift_operand(shift_operand), .signed_imm_24(signed_imm_24),
    .dest(dest), .src1(src1), .src2(src2), .two_src(two_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %h want %h", n, f, act, exp);
    end
  endtask

  // Inputs change just after each negedge, so posedge sees settled reads
  always @(posedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      chk(e.name, "ctl", {23'd0, wb_en, mem_r_en, mem_w_en, b, s, exe_cmd}, {23'd0, e.ctl});
      chk(e.name, "val_rn", val_rn, e.rn);
      chk(e.name, "val_rm", val_rm, e.rm);
      chk(e.name, "src1", {28'd0, src1}, {28'd0, e.src1});
      chk(e.name, "src2", {28'd0, src2}, {28'd0, e.src2});
      chk(e.name, "dest", {28'd0, dest}, {28'd0, e.dest});
      chk(e.name, "two_src", {31'd0, two_src}, {31'd0, e.two});
      chk(e.name, "fields", {7'd0, imm, shift_operand, 12'd0}, {7'd0, e.inst[25], e.inst[11:0], 12'd0});
      chk(e.name, "simm24", {8'd0, signed_imm_24}, {8'd0, e.inst[23:0]});
    end
  end

  task automatic vec(input string n, input logic [31:0] i, input logic [3:0] f, input logic hz,
                     input logic [8:0] ctl, input logic [31:0] rn, input logic [31:0] rm,
                     input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d, input logic two);
    exp_t e;
    @(negedge clk); #1;
    inst = i; sr = f; hazard = hz;
    e.name = n; e.inst = i; e.ctl = ctl; e.rn = rn; e.rm = rm;
    e.src1 = s1; e.src2 = s2; e.dest = d; e.two = two;
    q.push_back(e);
  endtask

  task automatic wr(input logic [3:0] d, input logic [31:0] v);
    @(negedge clk); #1;
    write_back_en = 1'b1; dest_wb = d; result_wb = v;
    @(negedge clk); #1;
    write_back_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; inst = '0; result_wb = '0; write_back_en = 1'b0;
    dest_wb = '0; hazard = 1'b0; sr = '0;
    #2 rst = 1'b0;
    #10 rst = 1'b1;

    //                                     wbmrmwbs cmd
    vec("reset_nop", 32'h0000_0000, 4'h0, 0, 9'b00000_0000, 0, 0, 0, 0, 0, 1);
    vec("add_imm",   32'hE282_3005, 4'h0, 0, 9'b10000_0010, 2, 5, 2, 5, 3, 0);
    vec("add_reg",   32'hE081_2003, 4'h0, 0, 9'b10000_0010, 1, 3, 1, 3, 2, 1);
    vec("str",       32'hE585_4000, 4'h0, 0, 9'b00100_0010, 5, 4, 5, 4, 4, 1);
    vec("ldr",       32'hE595_4000, 4'h0, 0, 9'b11000_0010, 5, 0, 5, 0, 4, 1);
    wr(4'd7, 32'hDEAD_BEEF);
    vec("rd_r7",     32'hE087_0001, 4'h0, 0, 9'b10000_0010, 32'hDEAD_BEEF, 1, 7, 1, 0, 1);
    wr(4'd15, 32'h1234_5678);
    vec("rd_r15",    32'hE08F_000E, 4'h0, 0, 9'b10000_0010, 0, 14, 15, 14, 0, 1);
    vec("r7_kept",   32'hE087_0001, 4'h0, 0, 9'b10000_0010, 32'hDEAD_BEEF, 1, 7, 1, 0, 1);
    vec("beq_z1",    32'h0A00_0010, 4'h4, 0, 9'b00010_0000, 0, 0, 0, 0, 0, 0);
    vec("beq_z0",    32'h0A00_0010, 4'h0, 0, 9'b00000_0000, 0, 0, 0, 0, 0, 0);
    vec("bal_hz",    32'hEA00_0010, 4'h0, 1, 9'b00000_0000, 0, 0, 0, 0, 0, 0);
    vec("bal",       32'hEA00_0010, 4'h0, 0, 9'b00010_0000, 0, 0, 0, 0, 0, 0);
    vec("cmp_s",     32'hE151_0002, 4'h0, 0, 9'b00001_0100, 1, 2, 1, 2, 0, 1);
    vec("gt_fail",   32'hC081_2003, 4'h8, 0, 9'b00000_0000, 1, 3, 1, 3, 2, 1);
    vec("mvn_imm",   32'hE3E0_0000, 4'h0, 0, 9'b10000_1001, 0, 0, 0, 0, 0, 0);
    vec("undef_op",  32'hE061_2003, 4'h0, 0, 9'b00000_0000, 1, 3, 1, 3, 2, 1);
    vec("mode11",    32'hEC00_0000, 4'h0, 0, 9'b00000_0000, 0, 0, 0, 0, 0, 1);
    vec("le_z1",     32'hD081_2003, 4'h4, 0, 9'b10000_0010, 1, 3, 1, 3, 2, 1);
    vec("hi_c1",     32'h8081_2003, 4'h2, 0, 9'b10000_0010, 1, 3, 1, 3, 2, 1);
    vec("nv",        32'hF081_2003, 4'h0, 0, 9'b00000_0000, 1, 3, 1, 3, 2, 1);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/arm_decode_stage.md
Name: arm_decode_stage

Overview:
- Instruction-decode stage of the 5-stage ARM968E-S-subset pipeline.
- Sits between the IF/ID pipeline register and the ID/EXE register.
- Holds the 15-entry register file, the control unit and the condition-check unit.
- Emits execute/memory/write-back controls, operand values and instruction fields for the EXE stage and the hazard unit.

Parameters:
- None. Data width is fixed at 32 and the register file has 15 entries.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- inst  in  32  instruction from IF/ID register
- result_wb  in  32  write-back data
- write_back_en  in  1  register-file write enable from WB stage
- dest_wb  in  4  write-back destination register
- hazard  in  1  stall/bubble request from hazard unit
- sr  in  4  status register {N,Z,C,V}
- wb_en  out  1  result is written to the register file
- mem_r_en  out  1  memory read (LDR)
- mem_w_en  out  1  memory write (STR)
- b  out  1  branch taken
- s  out  1  update status register
- exe_cmd  out  4  ALU command
- val_rn  out  32  RF[src1]
- val_rm  out  32  RF[src2]
- imm  out  1  inst[25]
- shift_operand  out  12  inst[11:0]
- signed_imm_24  out  24  inst[23:0]
- dest  out  4  inst[15:12]
- src1  out  4  inst[19:16]
- src2  out  4  second read address
- two_src  out  1  instruction reads a second register

Behaviour:
- Everything is combinational except the register file.
- Register file:
  - R0..R14, 32 bits each.
  - rst low: R[i] = i, asynchronously.
  - Write on the falling clk edge when write_back_en=1: R[dest_wb] = result_wb. A write to index 15 is ignored.
  - Reads are asynchronous. Reading index 15 returns 0.
  - A write on the negedge is visible on the read ports before the next posedge.
- Field decode:
  - mode = inst[27:26], opcode = inst[24:21], s_bit = inst[20].
  - src2 = inst[15:12] when raw mem_w (STR), else inst[3:0].
  - two_src = ~inst[25] | raw mem_w.
- Control unit, mode 00 (data processing), opcode -> exe_cmd, wb:
  - MOV 1101 -> 0001, wb=1
  - MVN 1111 -> 1001, wb=1
  - ADD 0100 -> 0010, wb=1
  - ADC 0101 -> 0011, wb=1
  - SUB 0010 -> 0100, wb=1
  - SBC 0110 -> 0101, wb=1
  - AND 0000 -> 0110, wb=1
  - ORR 1100 -> 0111, wb=1
  - EOR 0001 -> 1000, wb=1
  - CMP 1010 -> 0100, wb=0
  - TST 1000 -> 0110, wb=0
  - Any other opcode -> all controls 0.
  - s = s_bit.
- Control unit, mode 01 (memory):
  - s_bit=1: LDR, exe_cmd=0010, mem_r=1, wb=1, s=0.
  - s_bit=0: STR, exe_cmd=0010, mem_w=1, s=0.
- Control unit, mode 10: b=1, exe_cmd=0000, s=0.
- Control unit, mode 11: all controls 0.
- Condition check on cond = inst[31:28] with sr = {N,Z,C,V}:
  - EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V
  - HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V)
  - AL (1110) true; 1111 false.
- Bubble: if the condition fails or hazard=1, force wb_en, mem_r_en, mem_w_en, b, s and exe_cmd to 0.
  - Field outputs, val_rn/val_rm, src1/src2 and two_src still reflect inst.
- inst=0 (the IF/ID reset value) decodes as EQ with Z=0, i.e. a bubble.

Test Plan:
- Assert rst low, release; inst=0 -> all controls 0, val_rn=0, val_rm=0 (R0); inst={1110,00,1,0100,0,0010,0011,12'h005} -> val_rn=2.
- inst=32'hE0812003 (ADD R2,R1,R3, AL) -> wb_en=1, exe_cmd=0010, src1=1, src2=3, val_rn=1, val_rm=3, dest=2, imm=0, two_src=1.
- STR R4,[R5] AL (mode 01, s_bit=0) -> mem_w_en=1, exe_cmd=0010, src2=4, two_src=1, wb_en=0; LDR -> mem_r_en=1, wb_en=1.
- write_back_en=1, dest_wb=7, result_wb=32'hDEAD_BEEF across a falling edge -> inst reading R7 gives val_rn=32'hDEADBEEF; dest_wb=15 -> no register changes.
- BEQ (cond 0000, mode 10) with sr=0100 -> b=1; with sr=0000 -> b=0; AL branch with hazard=1 -> b=0, exe_cmd=0.
- CMP with S=1, AL -> exe_cmd=0100, s=1, wb_en=0; GT with sr N=1,V=0 -> all controls 0.
